// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer for a 4-bit combinational adder: adds two (4*NIBBLES)-bit operands
// one nibble per clock, LSB first, rippling the carry through a register.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_d;
  logic            cout_d;
  logic            busy_d;
  logic            done_d;
  logic [3:0]      fa_a_d, fa_b_d;
  logic            fa_cin_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (idx_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; adder inputs are registered so they
  // carry no combinational path from start or the operand inputs.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result;
    cout_d   = cout;
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    fa_a_d   = 4'd0;
    fa_b_d   = 4'd0;
    fa_cin_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a_in;
          b_sh_d   = b_in;
          carry_d  = cin;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
        end
      end
      S_RUN: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = fa_sum;
        end
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 4;
        b_sh_d  = b_sh_q >> 4;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) cout_d = fa_cout;
      end
      default: ;
    endcase

    if (state_d == S_RUN) begin
      fa_a_d   = a_sh_d[3:0];
      fa_b_d   = b_sh_d[3:0];
      fa_cin_d = carry_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fa_a    <= 4'd0;
      fa_b    <= 4'd0;
      fa_cin  <= 1'b0;
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      result  <= result_d;
      cout    <= cout_d;
      busy    <= busy_d;
      done    <= done_d;
      fa_a    <= fa_a_d;
      fa_b    <= fa_b_d;
      fa_cin  <= fa_cin_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: 4-nibble and 1-nibble instances, each
// closed around a behavioural 4-bit adder, checked against plain arithmetic.
module tb_nibble_serial_add_ctrl;

  logic clk;
  logic rst_n;

  logic        start4, cin4, busy4, done4, cout4, fa_cin4, fa_cout4;
  logic [15:0] a4, b4, res4;
  logic [3:0]  fa_a4, fa_b4, fa_sum4;

  logic        start1, cin1, busy1, done1, cout1, fa_cin1, fa_cout1;
  logic [3:0]  a1, b1, res1;
  logic [3:0]  fa_a1, fa_b1, fa_sum1;

  int checks = 0;
  int errors = 0;

  assign {fa_cout4, fa_sum4} = 5'(fa_a4) + 5'(fa_b4) + 5'(fa_cin4);
  assign {fa_cout1, fa_sum1} = 5'(fa_a1) + 5'(fa_b1) + 5'(fa_cin1);

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_cin(fa_cin4), .fa_sum(fa_sum4), .fa_cout(fa_cout4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One operation on the selected instance; called just after a negedge,
  // returns just after the negedge following busy's fall.
  task automatic do_op(input bit sel, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input bit hold);
    int          n;
    logic [31:0] av, bv, m, mj;
    logic [32:0] tot, part;
    logic [15:0] exp_res;
    logic        exp_cout;
    n  = sel ? 1 : 4;
    m  = (32'd1 << (4 * n)) - 32'd1;
    av = 32'(a) & m;
    bv = 32'(b) & m;
    tot      = 33'(av) + 33'(bv) + 33'(c);
    exp_res  = 16'(tot & 33'(m));
    exp_cout = 1'(tot >> (4 * n));

    if (sel) begin
      start1 = 1'b1; a1 = 4'(av); b1 = 4'(bv); cin1 = c;
    end else begin
      start4 = 1'b1; a4 = 16'(av); b4 = 16'(bv); cin4 = c;
    end
    @(posedge clk);
    @(negedge clk);

    for (int k = 1; k <= n + 1; k++) begin
      chk("busy", sel ? busy1 : busy4, 1'b1);
      chk("done", sel ? done1 : done4, (k == n + 1) ? 1'b1 : 1'b0);
      if (k <= n) begin
        mj   = (32'd1 << (4 * (k - 1))) - 32'd1;
        part = 33'(av & mj) + 33'(bv & mj) + 33'(c);
        chk("fa_a",   sel ? fa_a1 : fa_a4, 4'(av >> (4 * (k - 1))));
        chk("fa_b",   sel ? fa_b1 : fa_b4, 4'(bv >> (4 * (k - 1))));
        chk("fa_cin", sel ? fa_cin1 : fa_cin4, 1'(part >> (4 * (k - 1))));
      end else begin
        chk("fa_a_idle",   sel ? fa_a1 : fa_a4, 4'd0);
        chk("fa_cin_idle", sel ? fa_cin1 : fa_cin4, 1'b0);
        chk("result", sel ? 16'(res1) : res4, exp_res);
        chk("cout",   sel ? cout1 : cout4, exp_cout);
      end
      // Operands changing after capture must not disturb the add in flight
      if (sel) begin
        a1 = 4'($urandom); b1 = 4'($urandom); cin1 = 1'($urandom);
        if (!hold) start1 = 1'b0;
      end else begin
        a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
        if (!hold) start4 = 1'b0;
      end
      @(negedge clk);
    end

    chk("busy_end",    sel ? busy1 : busy4, 1'b0);
    chk("done_end",    sel ? done1 : done4, 1'b0);
    chk("result_hold", sel ? 16'(res1) : res4, exp_res);
    chk("cout_hold",   sel ? cout1 : cout4, exp_cout);
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_res4",  res4, 16'h0);
    chk("rst_cout4", cout4, 1'b0);
    chk("rst_fa4",   {fa_a4, fa_b4, fa_cin4}, 9'h0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_res1",  res1, 4'h0);
    chk("rst_fa1",   {fa_a1, fa_b1, fa_cin1}, 9'h0);
    rst_n = 1'b1;

    do_op(1'b0, 16'hB3A9, 16'h91D4, 1'b1, 1'b0);
    do_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b1);
    do_op(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    do_op(1'b1, 16'h000B, 16'h0009, 1'b1, 1'b0);
    do_op(1'b1, 16'h000F, 16'h000F, 1'b1, 1'b1);

    // Reset in the second RUN cycle aborts with no done pulse
    start4 = 1'b1; a4 = 16'hFFFF; b4 = 16'h0001; cin4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", busy4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy4, 1'b0);
    chk("abort_res",  res4, 16'h0);
    chk("abort_cout", cout4, 1'b0);
    chk("abort_fa",   {fa_a4, fa_b4, fa_cin4}, 9'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      chk("abort_nodone", done4, 1'b0);
    end
    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(($urandom_range(0, 3) == 0), 16'($urandom), 16'($urandom),
            1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
